// File: rtl/int_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_pkg
// Brief    : Shared types and constants for the intrinsic-LLR RAM sequencer.
// Revision : 1.0
// ============================================================================
package int_ram_pkg;

    localparam int INT_RAM_DATA_WIDTH = 5;
    localparam int INT_RAM_A_WIDTH    = 8;

    // Two's-complement LLR extremes for the default width
    localparam logic [INT_RAM_DATA_WIDTH-1:0] LLR_MIN = 5'b10000;
    localparam logic [INT_RAM_DATA_WIDTH-1:0] LLR_MAX = 5'b01111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/int_ram_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_seq_if
// Brief    : Input stream, output stream and INT_RAM port of the sequencer.
// Revision : 1.0
// ============================================================================
interface int_ram_seq_if
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = INT_RAM_DATA_WIDTH,
    parameter int A_WIDTH    = INT_RAM_A_WIDTH
) ();

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  frame_done;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_rs;
    logic [A_WIDTH-1:0]    ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  in_data, in_valid, out_ready, ram_dout,
        output in_ready, out_data, out_valid, out_last, frame_done,
        output ram_cs, ram_we, ram_rs, ram_addr, ram_din
    );

    modport slave (
        output in_data, in_valid, out_ready, ram_dout,
        input  in_ready, out_data, out_valid, out_last, frame_done,
        input  ram_cs, ram_we, ram_rs, ram_addr, ram_din
    );

endinterface
`default_nettype wire

// File: rtl/int_ram_seq_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_seq_fifo2
// Brief    : Two-entry skid FIFO with occupancy output; push while full is
//            accepted only when a pop frees a slot in the same cycle.
// Revision : 1.0
// ============================================================================
module int_ram_seq_fifo2 #(
    parameter int WIDTH = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      head_o,
    output logic [1:0]            occ_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop_i && (occ_q != 2'd0);
    assign w_push = push_i && ((occ_q != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/int_ram_seq.sv
`default_nettype none
// ============================================================================
// Module   : int_ram_seq
// Brief    : Loads one LLR frame into the current INT_RAM bank, reads it back
//            in address order to the decoder, then flips the bank.
//            Optional input symmetrisation + sat_cnt: INT_RAM_SEQ_SAT_EN.
// Revision : 1.0
// ============================================================================
module int_ram_seq
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = INT_RAM_DATA_WIDTH,
    parameter int A_WIDTH    = INT_RAM_A_WIDTH,
    parameter int FRAME_LEN  = 256
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    int_ram_seq_if.master bus
`ifdef INT_RAM_SEQ_SAT_EN
    ,
    output logic [A_WIDTH:0] sat_cnt
`endif
);

    localparam int               CNT_W     = A_WIDTH + 1;
    localparam int               FIFO_W    = DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

    seq_state_e            state_q;
    logic                  bank_q;
    logic [CNT_W-1:0]      wr_cnt_q;
    logic [CNT_W-1:0]      rd_cnt_q;
    logic                  in_ready_q;
    logic                  frame_done_q;
    logic                  rd_inflight_q;
    logic                  rd_inflight_last_q;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_credit;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_fifo_valid;
    logic [FIFO_W-1:0]     w_fifo_head;
    logic [1:0]            w_fifo_occ;

    assign w_wr       = bus.in_valid && in_ready_q;
    assign w_pop      = w_fifo_valid && bus.out_ready;
    assign w_last_pop = w_pop && w_fifo_head[DATA_WIDTH];

    // Buffered + in-flight words after this cycle's pop must leave room for one more
    assign w_credit = ({1'b0, w_fifo_occ} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, w_pop});
    assign w_rd     = (state_q == DRAIN) && (rd_cnt_q < FRAME_CNT) && w_credit;

`ifdef INT_RAM_SEQ_SAT_EN
    localparam logic [DATA_WIDTH-1:0] LLR_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] LLR_SYM = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    logic             w_sat;
    logic [A_WIDTH:0] sat_cnt_q;

    assign w_sat     = (bus.in_data == LLR_NEG);
    assign w_wr_data = w_sat ? LLR_SYM : bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (w_last_pop) begin
            sat_cnt_q <= '0;
        end else if (w_wr && w_sat) begin
            sat_cnt_q <= sat_cnt_q + CNT_ONE;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign w_wr_data = bus.in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            bank_q             <= 1'b0;
            wr_cnt_q           <= '0;
            rd_cnt_q           <= '0;
            in_ready_q         <= 1'b0;
            frame_done_q       <= 1'b0;
            rd_inflight_q      <= 1'b0;
            rd_inflight_last_q <= 1'b0;
        end else begin
            frame_done_q       <= 1'b0;
            rd_inflight_q      <= w_rd;
            rd_inflight_last_q <= w_rd && (rd_cnt_q == LAST_IDX);
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (w_wr) begin
                        wr_cnt_q <= wr_cnt_q + CNT_ONE;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_wr) begin
                        wr_cnt_q <= wr_cnt_q + CNT_ONE;
                        if (wr_cnt_q == LAST_IDX) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_rd) begin
                        rd_cnt_q <= rd_cnt_q + CNT_ONE;
                    end
                    if (w_last_pop) begin
                        state_q      <= IDLE;
                        bank_q       <= ~bank_q;
                        wr_cnt_q     <= '0;
                        rd_cnt_q     <= '0;
                        in_ready_q   <= 1'b1;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    int_ram_seq_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_inflight_q),
        .push_data_i ({rd_inflight_last_q, bus.ram_dout}),
        .pop_i       (w_pop),
        .valid_o     (w_fifo_valid),
        .head_o      (w_fifo_head),
        .occ_o       (w_fifo_occ)
    );

    // RAM strobes are combinational so the RAM samples them on the handshake edge
    assign bus.ram_cs   = w_wr || w_rd;
    assign bus.ram_we   = w_wr;
    assign bus.ram_rs   = bank_q;
    assign bus.ram_addr = w_wr ? wr_cnt_q[A_WIDTH-1:0] :
                          (w_rd ? rd_cnt_q[A_WIDTH-1:0] : '0);
    assign bus.ram_din  = w_wr ? w_wr_data : '0;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = w_fifo_valid;
    assign bus.out_data   = w_fifo_valid ? w_fifo_head[DATA_WIDTH-1:0] : '0;
    assign bus.out_last   = w_fifo_valid && w_fifo_head[DATA_WIDTH];
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_int_ram_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ram_seq
// Brief    : Self-checking bench for int_ram_seq with a two-bank INT_RAM model.
// Revision : 1.0
// ============================================================================
module tb_int_ram_seq;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int FL = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    logic model_bank;
    logic [DW-1:0] saved_words [FL];
    logic [DW-1:0] last_words  [FL];
    logic [DW-1:0] ram_mem [2][1<<AW];
`ifdef INT_RAM_SEQ_SAT_EN
    logic [AW:0] sat_cnt;
`endif

    int_ram_seq_if #(.DATA_WIDTH(DW), .A_WIDTH(AW)) bus ();

    int_ram_seq #(
        .DATA_WIDTH (DW),
        .A_WIDTH    (AW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef INT_RAM_SEQ_SAT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port INT_RAM: synchronous write, registered read data
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_rs][bus.ram_addr] <= bus.ram_din;
            else            bus.ram_dout <= ram_mem[bus.ram_rs][bus.ram_addr];
        end
    end

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] v);
`ifdef INT_RAM_SEQ_SAT_EN
        return (v == 5'b10000) ? 5'b10001 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},   int'(bus.in_ready),   0);
        chk({tag, "_out_valid"},  int'(bus.out_valid),  0);
        chk({tag, "_out_last"},   int'(bus.out_last),   0);
        chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
        chk({tag, "_ram_cs"},     int'(bus.ram_cs),     0);
        chk({tag, "_ram_we"},     int'(bus.ram_we),     0);
        chk({tag, "_ram_rs"},     int'(bus.ram_rs),     0);
        chk({tag, "_ram_addr"},   int'(bus.ram_addr),   0);
        chk({tag, "_ram_din"},    int'(bus.ram_din),    0);
        chk({tag, "_out_data"},   int'(bus.out_data),   0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        model_bank = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "_post_out_valid"}, int'(bus.out_valid), 0);
            chk({tag, "_post_ram_cs"},    int'(bus.ram_cs),    0);
        end
    endtask

    // data_mode: 0 = 0..FL-1, 1 = random with frequent most-negative, 2 = -16,5,-16,random
    task automatic run_frame(input int data_mode, input bit rand_ready, input bit hold_valid,
                             input int abort_w, input int abort_o);
        logic [DW-1:0] words [FL];
        int  wi, wc, rc, oc, cyc, lw_cyc, last_cyc, n_neg;
        bit  load_done, done, fv_seen, sat_checked;
        wi = 0; wc = 0; rc = 0; oc = 0; cyc = 0; lw_cyc = -100; last_cyc = -100; n_neg = 0;
        load_done = 0; done = 0; fv_seen = 0; sat_checked = 0;
        for (int i = 0; i < FL; i++) begin
            if (data_mode == 0)      words[i] = DW'(i);
            else if (data_mode == 2) words[i] = (i == 0 || i == 2) ? 5'b10000 :
                                                (i == 1) ? 5'd5 : DW'($urandom);
            else                     words[i] = ($urandom % 4 == 0) ? 5'b10000 : DW'($urandom);
            if (words[i] == 5'b10000) n_neg++;
        end
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.frame_done) begin
                chk("frame_done_lat", cyc - last_cyc, 1);
`ifdef INT_RAM_SEQ_SAT_EN
                chk("sat_cnt_clear", int'(sat_cnt), 0);
`endif
                done = 1;
                bus.in_valid = 1'b0;
                break;
            end
            bus.in_valid  = (wi < FL) ? ($urandom % 5 != 0) : hold_valid;
            bus.in_data   = (wi < FL) ? words[wi] : DW'($urandom);
            bus.out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            #1;
            if (load_done) begin
                chk("in_ready_drain", int'(bus.in_ready), 0);
`ifdef INT_RAM_SEQ_SAT_EN
                if (!sat_checked) chk("sat_cnt", int'(sat_cnt), n_neg);
`endif
                sat_checked = 1;
            end
            if (bus.in_valid && bus.in_ready) wi++;
            if (bus.ram_cs && bus.ram_we) begin
                chk("wr_addr", int'(bus.ram_addr), wc);
                chk("wr_rs",   int'(bus.ram_rs),   int'(model_bank));
                if (wc < FL) chk("wr_data", int'(bus.ram_din), int'(stored(words[wc])));
                wc++;
                if (wc == FL) begin
                    lw_cyc    = cyc;
                    load_done = 1;
                end
            end
            if (bus.ram_cs && !bus.ram_we) begin
                chk("rd_addr", int'(bus.ram_addr), rc);
                chk("rd_rs",   int'(bus.ram_rs),   int'(model_bank));
                rc++;
            end
            if (bus.out_valid && !fv_seen) begin
                fv_seen = 1;
                chk("first_valid_lat", cyc - lw_cyc, 3);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (oc < FL) chk("out_data", int'(bus.out_data), int'(stored(words[oc])));
                chk("out_last", int'(bus.out_last), int'(oc == FL - 1));
                if (bus.out_last) last_cyc = cyc;
                oc++;
            end
            chk("outstanding_le2", int'((rc - oc) <= 2), 1);
            if ((abort_w >= 0 && wi == abort_w) || (abort_o >= 0 && oc == abort_o)) return;
        end
        chk("frame_done_seen", int'(done), 1);
        chk("write_count",  wc, FL);
        chk("read_count",   rc, FL);
        chk("output_count", oc, FL);
        for (int i = 0; i < FL; i++) last_words[i] = words[i];
        model_bank = ~model_bank;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        model_bank    = 1'b0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 0..7, full throughput, bank 0
        run_frame(0, 1'b0, 1'b0, -1, -1);
        saved_words = last_words;
        // Bank 1 with in_valid held during drain
        run_frame(1, 1'b0, 1'b1, -1, -1);
        for (int i = 0; i < FL; i++)
            chk("bank0_kept", int'(ram_mem[0][i]), int'(stored(saved_words[i])));
        // Back on bank 0, random backpressure
        run_frame(1, 1'b1, 1'b0, -1, -1);
        run_frame(1, 1'b1, 1'b1, -1, -1);

        // Reset mid-LOAD after 3 words, then reset mid-DRAIN after 3 outputs
        run_frame(1, 1'b0, 1'b0, 3, -1);
        do_reset("rst_load");
        run_frame(1, 1'b1, 1'b0, -1, -1);
        run_frame(1, 1'b1, 1'b1, -1, 3);
        do_reset("rst_drain");

        // Most-negative inputs at the first bank-0 frame after reset
        run_frame(2, 1'b0, 1'b0, -1, -1);
        chk("ram_word0", int'(ram_mem[0][0]), int'(stored(5'b10000)));
        chk("ram_word1", int'(ram_mem[0][1]), 5);
        chk("ram_word2", int'(ram_mem[0][2]), int'(stored(5'b10000)));
        run_frame(1, 1'b1, 1'b0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
